action_rule_loader: RTL and testbench

- Control-plane writer for the Action Unit's per-field rule memories.
- Accepts one complete rule per valid/ready handshake. A rule is a PDR_ID, a field-select mask and nine field values.
- Serialises the rule into one-hot write cycles on the shared W_ADDR / Write_Enables / Write_Data bus that feeds the Single_Field_Unit memories.
- Sits between the host/config interface and the Action Unit write port.

---
 rtl/action_unit_pkg.sv | 24 ++
 rtl/action_rule_loader_if.sv | 32 +++
 rtl/action_rule_loader_field_mask_pick.sv | 24 ++
 rtl/action_rule_loader.sv | 157 +++++++++++++++
 tb/tb_action_rule_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/action_unit_pkg.sv
// Shared constants and types for the Action Unit rule-memory writer.
// Field indices name the nine Single_Field_Unit memories in bus order.
package action_unit_pkg;

    localparam int NUM_FIELDS  = 9;
    localparam int FIELD_IDX_W = $clog2(NUM_FIELDS);

    localparam int FIELD_IN_PORT          = 0;
    localparam int FIELD_SA_UNDERLAY      = 1;
    localparam int FIELD_DA_UNDERLAY      = 2;
    localparam int FIELD_GTPU_TEID        = 3;
    localparam int FIELD_GTPU_QFI         = 4;
    localparam int FIELD_SA_OVERLAY       = 5;
    localparam int FIELD_DA_OVERLAY       = 6;
    localparam int FIELD_SP_DP_OVERLAY    = 7;
    localparam int FIELD_PROTOCOL_OVERLAY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/action_rule_loader_if.sv
// Host-side rule handshake: one complete rule (PDR_ID, field mask, nine values)
// per valid/ready transfer. The loader is the slave.
interface action_rule_loader_if
    import action_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);

    logic                             rule_valid;
    logic                             rule_ready;
    logic [ADDR_WIDTH-1:0]            rule_pdr_id;
    logic [NUM_FIELDS-1:0]            rule_field_mask;
    logic [NUM_FIELDS*DATA_WIDTH-1:0] rule_data;

    modport master (
        output rule_valid,
        output rule_pdr_id,
        output rule_field_mask,
        output rule_data,
        input  rule_ready
    );

    modport slave (
        input  rule_valid,
        input  rule_pdr_id,
        input  rule_field_mask,
        input  rule_data,
        output rule_ready
    );

endinterface

// File: rtl/action_rule_loader_field_mask_pick.sv
// Combinational lowest-set-bit picker for the remaining field mask.
module field_mask_pick
    import action_unit_pkg::*;
#(
    parameter int WIDTH = NUM_FIELDS,
    parameter int IDX_W = FIELD_IDX_W
) (
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two's-complement isolates the lowest set bit; OR-ing indices is exact for a one-hot vector.
    always_comb begin
        onehot = mask & (~mask + WIDTH'(1));
        idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | (onehot[i] ? IDX_W'(i) : IDX_W'(0));
        end
        any = |mask;
    end

endmodule

// File: rtl/action_rule_loader.sv
// Serialises one rule per handshake into one-hot field-memory write cycles.
// Optional ACTION_LOADER_STATS_EN adds rules_loaded / writes_issued counters.
module action_rule_loader
    import action_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    action_rule_loader_if.slave   rule_if,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [NUM_FIELDS-1:0] Write_Enables,
    output logic [DATA_WIDTH-1:0] Write_Data,
    output logic                  busy,
    output logic                  rule_done
`ifdef ACTION_LOADER_STATS_EN
    ,
    output logic [15:0]           rules_loaded,
    output logic [15:0]           writes_issued
`endif
);

    loader_state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]            pdr_q, pdr_d;
    logic [NUM_FIELDS-1:0]            mask_q, mask_d;
    logic [NUM_FIELDS*DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]            waddr_q, waddr_d;
    logic [NUM_FIELDS-1:0]            we_q, we_d;
    logic [DATA_WIDTH-1:0]            wdata_q, wdata_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic [NUM_FIELDS-1:0]            pick_onehot_s;
    logic [FIELD_IDX_W-1:0]           pick_idx_s;
    logic                             pick_any_s;

    field_mask_pick #(
        .WIDTH (NUM_FIELDS),
        .IDX_W (FIELD_IDX_W)
    ) u_pick (
        .mask   (mask_q),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign rule_if.rule_ready = (state_q == IDLE);

    // Next-state and next-output computation; write bus holds address/data between strobes.
    always_comb begin
        state_d = state_q;
        pdr_d   = pdr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        waddr_d = waddr_q;
        we_d    = '0;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rule_if.rule_valid) begin
                    pdr_d   = rule_if.rule_pdr_id;
                    mask_d  = rule_if.rule_field_mask;
                    data_d  = rule_if.rule_data;
                    state_d = (|rule_if.rule_field_mask) ? WRITE : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (pick_any_s) begin
                    waddr_d = pdr_q;
                    we_d    = pick_onehot_s;
                    wdata_d = data_q[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    mask_d  = mask_q & ~pick_onehot_s;
                    state_d = (mask_d == '0) ? DONE : WRITE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, latched rule and registered write-bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pdr_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            waddr_q <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pdr_q   <= pdr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign W_ADDR        = waddr_q;
    assign Write_Enables = we_q;
    assign Write_Data    = wdata_q;
    assign busy          = busy_q;
    assign rule_done     = done_q;

`ifdef ACTION_LOADER_STATS_EN
    logic [15:0] rules_loaded_q, rules_loaded_d;
    logic [15:0] writes_issued_q, writes_issued_d;

    // Counters track the registered strobes actually seen on the outputs; both wrap.
    always_comb begin
        if (done_q) begin
            rules_loaded_d = rules_loaded_q + 16'd1;
        end else begin
            rules_loaded_d = rules_loaded_q;
        end
        if (we_q != '0) begin
            writes_issued_d = writes_issued_q + 16'd1;
        end else begin
            writes_issued_d = writes_issued_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rules_loaded_q  <= 16'd0;
            writes_issued_q <= 16'd0;
        end else begin
            rules_loaded_q  <= rules_loaded_d;
            writes_issued_q <= writes_issued_d;
        end
    end

    assign rules_loaded  = rules_loaded_q;
    assign writes_issued = writes_issued_q;
`endif

endmodule

// File: tb/tb_action_rule_loader.sv
// Directed self-checking bench for action_rule_loader (stats ports follow ACTION_LOADER_STATS_EN).
module tb_action_rule_loader;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int NF = 9;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] w_addr;
    logic [NF-1:0] w_en;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          rule_done;
`ifdef ACTION_LOADER_STATS_EN
    logic [15:0]   rules_loaded;
    logic [15:0]   writes_issued;
`endif

    action_rule_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rule_if ();

    action_rule_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rule_if       (rule_if),
        .W_ADDR        (w_addr),
        .Write_Enables (w_en),
        .Write_Data    (w_data),
        .busy          (busy),
        .rule_done     (rule_done)
`ifdef ACTION_LOADER_STATS_EN
        ,
        .rules_loaded  (rules_loaded),
        .writes_issued (writes_issued)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]    fld [NF];
    logic [NF*DW-1:0] bus;
    int               exp_idx [NF];

    // Passive monitor sampled on the falling edge.
    int               cyc = 0;
    int               done_cnt = 0;
    int               acc_cyc_q [$];
    logic [NF-1:0]    acc_mask_q [$];
    logic [AW+NF+DW-1:0] wr_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rule_if.rule_valid && rule_if.rule_ready) begin
            acc_cyc_q.push_back(cyc);
            acc_mask_q.push_back(rule_if.rule_field_mask);
        end
        if (w_en != '0) wr_q.push_back({w_addr, w_en, w_data});
        if (rule_done) done_cnt = done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_bus(input logic [DW-1:0] base);
        for (int k = 0; k < NF; k++) begin
            fld[k] = base + DW'(k);
            bus[k*DW +: DW] = fld[k];
        end
    endtask

    // Presents one rule, then checks n write cycles against exp_idx[], the done pulse and return to idle.
    task automatic do_rule(input string tag, input logic [AW-1:0] pdr, input logic [NF-1:0] mask, input int n);
        int cnt;
        rule_if.rule_valid      = 1'b1;
        rule_if.rule_pdr_id     = pdr;
        rule_if.rule_field_mask = mask;
        rule_if.rule_data       = bus;
        cnt = 0;
        while (rule_if.rule_ready !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check_val({tag, "_ready"}, 64'(rule_if.rule_ready), 64'd1);
        tick();
        rule_if.rule_valid = 1'b0;
        check_val({tag, "_busy0"}, 64'(busy), 64'd1);
        check_val({tag, "_nowr0"}, 64'(w_en), 64'd0);
        check_val({tag, "_nodone0"}, 64'(rule_done), 64'd0);
        for (int k = 0; k < n; k++) begin
            tick();
            check_val($sformatf("%s_we%0d", tag, k), 64'(w_en), 64'(9'd1 << exp_idx[k]));
            check_val($sformatf("%s_addr%0d", tag, k), 64'(w_addr), 64'(pdr));
            check_val($sformatf("%s_data%0d", tag, k), 64'(w_data), 64'(fld[exp_idx[k]]));
            check_val($sformatf("%s_done%0d", tag, k), 64'(rule_done), 64'd0);
        end
        tick();
        check_val({tag, "_done"}, 64'(rule_done), 64'd1);
        check_val({tag, "_we_off"}, 64'(w_en), 64'd0);
        check_val({tag, "_busy_off"}, 64'(busy), 64'd0);
        if (n > 0) begin
            check_val({tag, "_addr_hold"}, 64'(w_addr), 64'(pdr));
            check_val({tag, "_data_hold"}, 64'(w_data), 64'(fld[exp_idx[n-1]]));
        end
        tick();
        check_val({tag, "_done_pulse"}, 64'(rule_done), 64'd0);
        check_val({tag, "_ready_after"}, 64'(rule_if.rule_ready), 64'd1);
    endtask

    task automatic garbage();
        rule_if.rule_pdr_id     = 2'd0;
        rule_if.rule_field_mask = 9'h0F0;
        rule_if.rule_data       = {NF{32'hFFFF_FFFF}};
    endtask

    initial begin
        int cnt;
        int d_before;
        rst_n = 1'b0;
        rule_if.rule_valid      = 1'b0;
        rule_if.rule_pdr_id     = '0;
        rule_if.rule_field_mask = '0;
        rule_if.rule_data       = '0;
        tick();
        tick();
        check_val("rst_addr", 64'(w_addr), 64'd0);
        check_val("rst_we", 64'(w_en), 64'd0);
        check_val("rst_data", 64'(w_data), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(rule_done), 64'd0);
        check_val("rst_ready", 64'(rule_if.rule_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single field.
        build_bus(32'hDEAD_BEEF);
        exp_idx[0] = 0;
        do_rule("single", 2'd2, 9'h001, 1);

        // Sparse mask 1A5: fields 0,2,5,7,8.
        build_bus(32'h1234_5600);
        exp_idx[0] = 0; exp_idx[1] = 2; exp_idx[2] = 5; exp_idx[3] = 7; exp_idx[4] = 8;
        do_rule("sparse", 2'd1, 9'h1A5, 5);

        // Empty mask.
        build_bus(32'h7777_0000);
        do_rule("empty", 2'd3, 9'h000, 0);

        // Back-to-back with valid held; inputs during busy are garbage.
        acc_cyc_q.delete(); acc_mask_q.delete(); wr_q.delete();
        d_before = done_cnt;
        build_bus(32'hA000_0000);
        rule_if.rule_valid = 1'b1;
        rule_if.rule_pdr_id = 2'd1; rule_if.rule_field_mask = 9'h1FF; rule_if.rule_data = bus;
        tick();
        garbage();
        cnt = 0;
        while (rule_if.rule_ready !== 1'b1 && cnt < 30) begin tick(); cnt++; end
        build_bus(32'hB0B0_0000);
        rule_if.rule_pdr_id = 2'd2; rule_if.rule_field_mask = 9'h002; rule_if.rule_data = bus;
        tick();
        garbage();
        cnt = 0;
        while (rule_if.rule_ready !== 1'b1 && cnt < 30) begin tick(); cnt++; end
        rule_if.rule_pdr_id = 2'd3; rule_if.rule_field_mask = 9'h000;
        tick();
        rule_if.rule_valid = 1'b0;
        tick(); tick(); tick();
        check_val("b2b_nacc", 64'(acc_cyc_q.size()), 64'd3);
        if (acc_cyc_q.size() == 3) begin
            check_val("b2b_gap1", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd11);
            check_val("b2b_gap2", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd3);
            check_val("b2b_mask0", 64'(acc_mask_q[0]), 64'h1FF);
            check_val("b2b_mask1", 64'(acc_mask_q[1]), 64'h002);
            check_val("b2b_mask2", 64'(acc_mask_q[2]), 64'h000);
        end
        check_val("b2b_nwr", 64'(wr_q.size()), 64'd10);
        if (wr_q.size() == 10) begin
            for (int k = 0; k < 9; k++) begin
                check_val($sformatf("b2b_wr%0d", k), 64'(wr_q[k]),
                          64'({2'd1, 9'd1 << k, 32'hA000_0000 + 32'(k)}));
            end
            check_val("b2b_wr9", 64'(wr_q[9]), 64'({2'd2, 9'h002, 32'hB0B0_0001}));
        end
        check_val("b2b_dones", 64'(done_cnt - d_before), 64'd3);
        check_val("b2b_idle", 64'(rule_if.rule_ready), 64'd1);

        // Reset on the third write of a full-mask rule.
        build_bus(32'h5000_0000);
        rule_if.rule_valid = 1'b1;
        rule_if.rule_pdr_id = 2'd3; rule_if.rule_field_mask = 9'h1FF; rule_if.rule_data = bus;
        check_val("mid_ready", 64'(rule_if.rule_ready), 64'd1);
        tick();
        rule_if.rule_valid = 1'b0;
        tick(); tick(); tick();
        check_val("mid_we3", 64'(w_en), 64'h004);
        d_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check_val("mid_we_async", 64'(w_en), 64'd0);
        check_val("mid_busy_async", 64'(busy), 64'd0);
        tick(); tick();
        check_val("mid_no_done", 64'(done_cnt - d_before), 64'd0);
        rst_n = 1'b1;
        tick();
        check_val("mid_ready_after", 64'(rule_if.rule_ready), 64'd1);
        check_val("mid_no_done2", 64'(done_cnt - d_before), 64'd0);
        for (int k = 0; k < NF; k++) exp_idx[k] = k;
        build_bus(32'hC000_0000);
        do_rule("full", 2'd3, 9'h1FF, 9);
        build_bus(32'hD000_0000);
        exp_idx[0] = 0; exp_idx[1] = 1;
        do_rule("two", 2'd0, 9'h003, 2);
`ifdef ACTION_LOADER_STATS_EN
        check_val("stats_rules", 64'(rules_loaded), 64'd2);
        check_val("stats_writes", 64'(writes_issued), 64'd11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
